// File: rtl/triumph_pipe_ctrl_pkg.sv
// Shared defines for the Triumph pipeline controller: instruction classes,
// opcodes, mux select codes, branch funct3 codes and the branch-condition helper.
package triumph_pipe_ctrl_pkg;

  localparam logic [2:0] INSTR_R = 3'd0;
  localparam logic [2:0] INSTR_I = 3'd1;
  localparam logic [2:0] INSTR_S = 3'd2;
  localparam logic [2:0] INSTR_B = 3'd3;
  localparam logic [2:0] INSTR_U = 3'd4;
  localparam logic [2:0] INSTR_J = 3'd5;

  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [1:0] PC_SEL_SEQ  = 2'd0;
  localparam logic [1:0] PC_SEL_BR   = 2'd1;
  localparam logic [1:0] PC_SEL_JAL  = 2'd2;
  localparam logic [1:0] PC_SEL_JALR = 2'd3;

  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_MEM = 2'd1;
  localparam logic [1:0] WB_SEL_PC4 = 2'd2;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  localparam logic [2:0] BR_F3_BEQ  = 3'b000;
  localparam logic [2:0] BR_F3_BNE  = 3'b001;
  localparam logic [2:0] BR_F3_BLT  = 3'b100;
  localparam logic [2:0] BR_F3_BGE  = 3'b101;
  localparam logic [2:0] BR_F3_BLTU = 3'b110;
  localparam logic [2:0] BR_F3_BGEU = 3'b111;

  typedef enum logic {ST_RUN, ST_MEM_WAIT} ctrl_state_e;

  function automatic logic br_taken(input logic [2:0] f3, input logic z,
                                    input logic lt, input logic ltu);
    case (f3)
      BR_F3_BEQ:  br_taken = z;
      BR_F3_BNE:  br_taken = !z;
      BR_F3_BLT:  br_taken = lt;
      BR_F3_BGE:  br_taken = !lt;
      BR_F3_BLTU: br_taken = ltu;
      BR_F3_BGEU: br_taken = !ltu;
      default:    br_taken = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/triumph_hazard_unit.sv
// Combinational RAW / load-use detection for the ID instruction and EX operand
// forwarding selects. TRIUMPH_FWD_EN enables forwarding; otherwise RAW stalls.
module triumph_hazard_unit
  import triumph_pipe_ctrl_pkg::*;
#(
  parameter int RF_ADDR_W = 5
) (
  input  logic                      id_valid_i,
  input  logic [1:0]                use_rs_i,
  input  logic [1:0][RF_ADDR_W-1:0] rs_id_i,
  input  logic [1:0][RF_ADDR_W-1:0] rs_ex_i,
  input  logic                      ex_valid_i,
  input  logic                      ex_we_i,
  input  logic                      ex_is_load_i,
  input  logic [RF_ADDR_W-1:0]      ex_rd_i,
  input  logic                      mem_valid_i,
  input  logic                      mem_we_i,
  input  logic [RF_ADDR_W-1:0]      mem_rd_i,
  input  logic                      wb_valid_i,
  input  logic                      wb_we_i,
  input  logic [RF_ADDR_W-1:0]      wb_rd_i,
  output logic                      stall_o,
  output logic [1:0][1:0]           fwd_sel_o
);

  function automatic logic writes(input logic v, input logic we,
                                  input logic [RF_ADDR_W-1:0] rd,
                                  input logic [RF_ADDR_W-1:0] rs);
    return v && we && (rd != '0) && (rd == rs);
  endfunction

  logic [1:0] raw_ex;
`ifndef TRIUMPH_FWD_EN
  logic [1:0] raw_mw;
`endif

  for (genvar s = 0; s < 2; s++) begin : g_src
    assign raw_ex[s] = use_rs_i[s] && writes(ex_valid_i, ex_we_i, ex_rd_i, rs_id_i[s]);
`ifdef TRIUMPH_FWD_EN
    // MEM is the younger writer, so it shadows WB
    assign fwd_sel_o[s] = (rs_ex_i[s] == '0) ? FWD_RF :
                          writes(mem_valid_i, mem_we_i, mem_rd_i, rs_ex_i[s]) ? FWD_MEM :
                          writes(wb_valid_i, wb_we_i, wb_rd_i, rs_ex_i[s]) ? FWD_WB : FWD_RF;
`else
    assign raw_mw[s] = use_rs_i[s] &&
                       (writes(mem_valid_i, mem_we_i, mem_rd_i, rs_id_i[s]) ||
                        writes(wb_valid_i, wb_we_i, wb_rd_i, rs_id_i[s]));
    assign fwd_sel_o[s] = FWD_RF;
`endif
  end

`ifdef TRIUMPH_FWD_EN
  assign stall_o = id_valid_i && ex_is_load_i && (|raw_ex);
`else
  assign stall_o = id_valid_i && ((|raw_ex) || (|raw_mw));
  logic unused_hz;
  assign unused_hz = ^{rs_ex_i, ex_is_load_i};
`endif

endmodule

// File: rtl/triumph_pipe_ctrl.sv
// Pipeline controller: EX/MEM/WB control words, redirects, stalls, dcache wait
// FSM with sticky timeout. Build with TRIUMPH_FWD_EN for operand forwarding.
module triumph_pipe_ctrl
  import triumph_pipe_ctrl_pkg::*;
#(
  parameter int RF_ADDR_W    = 5,
  parameter int WB_SEL_W     = 2,
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 id_valid_i,
  input  logic [2:0]           instr_type_i,
  input  logic [6:0]           opcode_i,
  input  logic [2:0]           funct3_i,
  input  logic [RF_ADDR_W-1:0] rs1_i,
  input  logic [RF_ADDR_W-1:0] rs2_i,
  input  logic [RF_ADDR_W-1:0] rd_i,
  input  logic                 use_rs1_i,
  input  logic                 use_rs2_i,
  input  logic                 flag_zero_ex_i,
  input  logic                 flag_lt_ex_i,
  input  logic                 flag_ltu_ex_i,
  input  logic                 dcache_ready_i,
  output logic                 stall_o,
  output logic                 flush_id_o,
  output logic [1:0]           pc_mux_o,
  output logic                 dcache_req_o,
  output logic                 dcache_we_o,
  output logic [WB_SEL_W-1:0]  wb_sel_o,
  output logic                 rf_we_wb_o,
  output logic [RF_ADDR_W-1:0] rd_wb_o,
  output logic [1:0]           fwd_a_sel_o,
  output logic [1:0]           fwd_b_sel_o,
  output logic                 mem_timeout_o
);

  typedef struct packed {
    logic                 valid;
    logic [2:0]           itype;
    logic                 is_load;
    logic                 is_store;
    logic                 is_jalr;
    logic [2:0]           funct3;
    logic [RF_ADDR_W-1:0] rd;
    logic                 we;
    logic [WB_SEL_W-1:0]  wb_sel;
  } ctrl_word_t;

  localparam logic [7:0] WAIT_MAX8 = 8'(MEM_WAIT_MAX);

  ctrl_word_t id_word, ex_d, ex_q, mem_d, mem_q, wb_d, wb_q;
  logic [1:0][RF_ADDR_W-1:0] rs_ex_d, rs_ex_q;
  logic [1:0][1:0] fwd_sel;
  logic [1:0] pc_sel;
  logic ex_br, ex_jal, ex_jalr, redirect, mem_busy, hz_stall, stall_id;
  ctrl_state_e state_q;
  logic [7:0] wait_cnt_q, wait_cnt_inc;
  logic timeout_q;

  always_comb begin
    id_word          = '0;
    id_word.valid    = id_valid_i;
    id_word.itype    = instr_type_i;
    id_word.is_load  = (instr_type_i == INSTR_I) && (opcode_i == OP_LOAD);
    id_word.is_store = (instr_type_i == INSTR_S);
    id_word.is_jalr  = (instr_type_i == INSTR_I) && (opcode_i == OP_JALR);
    id_word.funct3   = funct3_i;
    id_word.rd       = rd_i;
    id_word.we       = (instr_type_i != INSTR_S) && (instr_type_i != INSTR_B) && (rd_i != '0);
    if (id_word.is_load)
      id_word.wb_sel = WB_SEL_W'(WB_SEL_MEM);
    else if (id_word.is_jalr || instr_type_i == INSTR_J)
      id_word.wb_sel = WB_SEL_W'(WB_SEL_PC4);
    else
      id_word.wb_sel = WB_SEL_W'(WB_SEL_ALU);
  end

  assign ex_br    = ex_q.valid && (ex_q.itype == INSTR_B) &&
                    br_taken(ex_q.funct3, flag_zero_ex_i, flag_lt_ex_i, flag_ltu_ex_i);
  assign ex_jal   = ex_q.valid && (ex_q.itype == INSTR_J);
  assign ex_jalr  = ex_q.valid && ex_q.is_jalr;
  assign redirect = ex_br || ex_jal || ex_jalr;
  assign mem_busy = mem_q.valid && (mem_q.is_load || mem_q.is_store) && !dcache_ready_i;

  always_comb begin
    pc_sel = PC_SEL_SEQ;
    if (ex_jalr)     pc_sel = PC_SEL_JALR;
    else if (ex_jal) pc_sel = PC_SEL_JAL;
    else if (ex_br)  pc_sel = PC_SEL_BR;
  end

  triumph_hazard_unit #(.RF_ADDR_W(RF_ADDR_W)) u_hazard (
    .id_valid_i   (id_valid_i),
    .use_rs_i     ({use_rs2_i, use_rs1_i}),
    .rs_id_i      ({rs2_i, rs1_i}),
    .rs_ex_i      (rs_ex_q),
    .ex_valid_i   (ex_q.valid),
    .ex_we_i      (ex_q.we),
    .ex_is_load_i (ex_q.is_load),
    .ex_rd_i      (ex_q.rd),
    .mem_valid_i  (mem_q.valid),
    .mem_we_i     (mem_q.we),
    .mem_rd_i     (mem_q.rd),
    .wb_valid_i   (wb_q.valid),
    .wb_we_i      (wb_q.we),
    .wb_rd_i      (wb_q.rd),
    .stall_o      (hz_stall),
    .fwd_sel_o    (fwd_sel)
  );

  // A redirect squashes the ID instruction, so its hazard no longer matters
  assign stall_id = hz_stall && !redirect;

  always_comb begin
    ex_d    = ex_q;
    mem_d   = mem_q;
    wb_d    = wb_q;
    rs_ex_d = rs_ex_q;
    if (!mem_busy) begin
      wb_d  = mem_q;
      mem_d = ex_q;
      if (!id_valid_i || redirect || stall_id) begin
        ex_d    = '0;
        rs_ex_d = '0;
      end else begin
        ex_d    = id_word;
        rs_ex_d = {use_rs2_i ? rs2_i : '0, use_rs1_i ? rs1_i : '0};
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      rs_ex_q <= '0;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      rs_ex_q <= rs_ex_d;
    end
  end

  assign wait_cnt_inc = (wait_cnt_q >= WAIT_MAX8) ? wait_cnt_q : wait_cnt_q + 8'd1;

  // Every cycle with MEM stuck counts, including the first one seen in RUN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (mem_busy) begin
            state_q    <= ST_MEM_WAIT;
            wait_cnt_q <= wait_cnt_inc;
            if (wait_cnt_inc >= WAIT_MAX8) timeout_q <= 1'b1;
          end
        end
        ST_MEM_WAIT: begin
          if (mem_busy) begin
            wait_cnt_q <= wait_cnt_inc;
            if (wait_cnt_inc >= WAIT_MAX8) timeout_q <= 1'b1;
          end else begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign stall_o       = mem_busy || stall_id;
  assign flush_id_o    = redirect && !mem_busy;
  assign pc_mux_o      = mem_busy ? PC_SEL_SEQ : pc_sel;
  assign dcache_req_o  = mem_q.valid && (mem_q.is_load || mem_q.is_store);
  assign dcache_we_o   = dcache_req_o && mem_q.is_store;
  assign wb_sel_o      = wb_q.wb_sel;
  assign rf_we_wb_o    = wb_q.valid && wb_q.we;
  assign rd_wb_o       = wb_q.rd;
  assign fwd_a_sel_o   = fwd_sel[0];
  assign fwd_b_sel_o   = fwd_sel[1];
  assign mem_timeout_o = timeout_q;

  logic unused_wb;
  assign unused_wb = ^wb_q;

endmodule

// File: tb/tb_triumph_pipe_ctrl.sv
// Bench for triumph_pipe_ctrl: vector table for decode/redirects, WB scoreboard,
// and directed sequences for hazards, dcache wait, timeout and reset.
module tb_triumph_pipe_ctrl;
  import triumph_pipe_ctrl_pkg::*;

`ifdef TRIUMPH_FWD_EN
  localparam int EXP_LU_STALL = 1;
  localparam int EXP_FWD_A    = 2;
`else
  localparam int EXP_LU_STALL = 3;
  localparam int EXP_FWD_A    = 0;
`endif

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_IMM = 7'b0010011;
  localparam logic [6:0] OPC_ST  = 7'b0100011;
  localparam logic [6:0] OPC_BR  = 7'b1100011;
  localparam logic [6:0] OPC_LUI = 7'b0110111;

  logic clk_i = 1'b0, rst_ni = 1'b0;
  logic id_valid_i = 0, use_rs1_i = 0, use_rs2_i = 0;
  logic [2:0] instr_type_i = '0, funct3_i = '0;
  logic [6:0] opcode_i = '0;
  logic [4:0] rs1_i = '0, rs2_i = '0, rd_i = '0;
  logic flag_zero_ex_i = 0, flag_lt_ex_i = 0, flag_ltu_ex_i = 0, dcache_ready_i = 1;
  logic stall_o, flush_id_o, dcache_req_o, dcache_we_o, rf_we_wb_o, mem_timeout_o;
  logic [1:0] pc_mux_o, wb_sel_o, fwd_a_sel_o, fwd_b_sel_o;
  logic [4:0] rd_wb_o;

  triumph_pipe_ctrl #(.RF_ADDR_W(5), .WB_SEL_W(2), .MEM_WAIT_MAX(15)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .id_valid_i(id_valid_i), .instr_type_i(instr_type_i),
    .opcode_i(opcode_i), .funct3_i(funct3_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i),
    .use_rs1_i(use_rs1_i), .use_rs2_i(use_rs2_i), .flag_zero_ex_i(flag_zero_ex_i),
    .flag_lt_ex_i(flag_lt_ex_i), .flag_ltu_ex_i(flag_ltu_ex_i), .dcache_ready_i(dcache_ready_i),
    .stall_o(stall_o), .flush_id_o(flush_id_o), .pc_mux_o(pc_mux_o), .dcache_req_o(dcache_req_o),
    .dcache_we_o(dcache_we_o), .wb_sel_o(wb_sel_o), .rf_we_wb_o(rf_we_wb_o), .rd_wb_o(rd_wb_o),
    .fwd_a_sel_o(fwd_a_sel_o), .fwd_b_sel_o(fwd_b_sel_o), .mem_timeout_o(mem_timeout_o)
  );

  always #5 clk_i = ~clk_i;

  wire [18:0] all_outs = {stall_o, flush_id_o, pc_mux_o, dcache_req_o, dcache_we_o, wb_sel_o,
                          rf_we_wb_o, rd_wb_o, fwd_a_sel_o, fwd_b_sel_o, mem_timeout_o};

  int checks = 0, errors = 0;

  typedef struct packed { logic [4:0] rd; logic [1:0] wbs; } wb_exp_t;
  wb_exp_t sb[$];

  typedef struct {
    logic [2:0] ty; logic [6:0] op; logic [2:0] f3; logic [4:0] rd;
    logic z, lt, ltu; logic [1:0] pc; logic we; logic [1:0] wbs;
  } vec_t;
  vec_t vt[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [4:0] rd, input logic [1:0] wbs);
    wb_exp_t e;
    e.rd = rd; e.wbs = wbs;
    sb.push_back(e);
  endtask

  task automatic drive_id(input logic [2:0] ty, input logic [6:0] op, input logic [2:0] f3,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic u1, input logic u2);
    id_valid_i = 1'b1; instr_type_i = ty; opcode_i = op; funct3_i = f3;
    rs1_i = rs1; rs2_i = rs2; rd_i = rd; use_rs1_i = u1; use_rs2_i = u2;
  endtask

  task automatic idle_id();
    id_valid_i = 1'b0; use_rs1_i = 1'b0; use_rs2_i = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  // WB scoreboard: every register write must match the oldest expected write
  wb_exp_t got;
  always @(negedge clk_i) begin
    if (rst_ni && rf_we_wb_o) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL wb_unexpected: rd %0d written, expected no write", rd_wb_o);
      end else begin
        got = sb.pop_front();
        chk("wb_rd", 32'(rd_wb_o), 32'(got.rd));
        chk("wb_sel", 32'(wb_sel_o), 32'(got.wbs));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int n;
    vt[0]  = '{INSTR_R, OPC_R,   3'b000, 5'd3,  1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0};
    vt[1]  = '{INSTR_I, OP_LOAD, 3'b010, 5'd5,  1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 2'd1};
    vt[2]  = '{INSTR_S, OPC_ST,  3'b010, 5'd9,  1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0};
    vt[3]  = '{INSTR_U, OPC_LUI, 3'b000, 5'd10, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0};
    vt[4]  = '{INSTR_J, OP_JAL,  3'b000, 5'd1,  1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 2'd2};
    vt[5]  = '{INSTR_I, OP_JALR, 3'b000, 5'd0,  1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 2'd0};
    vt[6]  = '{INSTR_I, OP_JALR, 3'b000, 5'd4,  1'b0, 1'b0, 1'b0, 2'd3, 1'b1, 2'd2};
    vt[7]  = '{INSTR_R, OPC_R,   3'b000, 5'd0,  1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0};
    vt[8]  = '{INSTR_B, OPC_BR,  3'b000, 5'd0,  1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 2'd0};
    vt[9]  = '{INSTR_B, OPC_BR,  3'b000, 5'd0,  1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0};
    vt[10] = '{INSTR_B, OPC_BR,  3'b001, 5'd0,  1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 2'd0};
    vt[11] = '{INSTR_B, OPC_BR,  3'b100, 5'd0,  1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 2'd0};
    vt[12] = '{INSTR_B, OPC_BR,  3'b101, 5'd0,  1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0};
    vt[13] = '{INSTR_B, OPC_BR,  3'b110, 5'd0,  1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 2'd0};
    vt[14] = '{INSTR_B, OPC_BR,  3'b111, 5'd0,  1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 2'd0};
    vt[15] = '{INSTR_B, OPC_BR,  3'b010, 5'd0,  1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 2'd0};
    vt[16] = '{INSTR_I, OPC_IMM, 3'b000, 5'd12, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0};

    // Reset state
    #12;
    chk("reset_outs", 32'(all_outs), 32'd0);
    @(negedge clk_i); rst_ni = 1'b1;
    tick();
    @(negedge clk_i);
    chk("post_reset_outs", 32'(all_outs), 32'd0);
    tick();

    // Decode and redirect table: one instruction, then one idle slot
    for (int i = 0; i < 17; i++) begin
      drive_id(vt[i].ty, vt[i].op, vt[i].f3, 5'd0, 5'd0, vt[i].rd, 1'b0, 1'b0);
      tick();
      if (vt[i].we) push_exp(vt[i].rd, vt[i].wbs);
      idle_id();
      flag_zero_ex_i = vt[i].z; flag_lt_ex_i = vt[i].lt; flag_ltu_ex_i = vt[i].ltu;
      @(negedge clk_i);
      chk($sformatf("vec%0d_pc_mux", i), 32'(pc_mux_o), 32'(vt[i].pc));
      chk($sformatf("vec%0d_flush", i), 32'(flush_id_o), 32'(vt[i].pc != 2'd0));
      chk($sformatf("vec%0d_stall", i), 32'(stall_o), 32'd0);
      tick();
    end
    flag_zero_ex_i = 0; flag_lt_ex_i = 0; flag_ltu_ex_i = 0;
    repeat (3) tick();
    chk("table_drain", 32'(sb.size()), 32'd0);

    // Load-use: LW x5 ; ADD x6,x5,x1
    drive_id(INSTR_I, OP_LOAD, 3'b010, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0);
    tick();
    push_exp(5'd5, 2'd1);
    drive_id(INSTR_R, OPC_R, 3'b000, 5'd5, 5'd1, 5'd6, 1'b1, 1'b1);
    n = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_i);
      if (!stall_o) break;
      n++;
      tick();
    end
    chk("lu_stall_cycles", 32'(n), 32'(EXP_LU_STALL));
    tick();
    push_exp(5'd6, 2'd0);
    idle_id();
    @(negedge clk_i);
    chk("lu_fwd_a", 32'(fwd_a_sel_o), 32'(EXP_FWD_A));
    chk("lu_fwd_b", 32'(fwd_b_sel_o), 32'd0);
    repeat (3) tick();

    // SW waits 3 cycles in MEM while a taken BNE sits in EX
    drive_id(INSTR_S, OPC_ST, 3'b010, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    tick();
    drive_id(INSTR_B, OPC_BR, BR_F3_BNE, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    flag_zero_ex_i = 1'b0; dcache_ready_i = 1'b0;
    @(negedge clk_i);
    chk("sw_pre_stall", 32'(stall_o), 32'd0);
    tick();
    idle_id();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      chk($sformatf("sw_wait%0d_stall", k), 32'(stall_o), 32'd1);
      chk($sformatf("sw_wait%0d_req_we", k), 32'({dcache_req_o, dcache_we_o}), 32'd3);
      chk($sformatf("sw_wait%0d_pc_flush", k), 32'({pc_mux_o, flush_id_o}), 32'd0);
      tick();
    end
    dcache_ready_i = 1'b1;
    @(negedge clk_i);
    chk("sw_done_stall", 32'(stall_o), 32'd0);
    chk("sw_done_pc_mux", 32'(pc_mux_o), 32'd1);
    chk("sw_done_flush", 32'(flush_id_o), 32'd1);
    tick();
    @(negedge clk_i);
    chk("sw_after_req", 32'(dcache_req_o), 32'd0);
    chk("sw_after_pc_mux", 32'(pc_mux_o), 32'd0);
    tick();
    tick();

    // Timeout: LW held in MEM for 20 cycles
    drive_id(INSTR_I, OP_LOAD, 3'b010, 5'd0, 5'd0, 5'd8, 1'b0, 1'b0);
    tick();
    push_exp(5'd8, 2'd1);
    idle_id();
    dcache_ready_i = 1'b0;
    tick();
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk_i);
      chk($sformatf("timeout_wait%0d", k), 32'(mem_timeout_o), 32'(k >= 16));
      tick();
    end
    dcache_ready_i = 1'b1;
    repeat (3) tick();
    @(negedge clk_i);
    chk("timeout_sticky", 32'(mem_timeout_o), 32'd1);
    chk("timeout_recovered_stall", 32'(stall_o), 32'd0);
    tick();
    chk("timeout_drain", 32'(sb.size()), 32'd0);

    // Reset mid-stream with a load waiting in MEM
    drive_id(INSTR_I, OP_LOAD, 3'b010, 5'd0, 5'd0, 5'd9, 1'b0, 1'b0);
    tick();
    idle_id();
    dcache_ready_i = 1'b0;
    tick();
    @(negedge clk_i);
    chk("pre_reset_req", 32'(dcache_req_o), 32'd1);
    #1 rst_ni = 1'b0;
    #1 chk("mid_reset_outs", 32'(all_outs), 32'd0);
    tick();
    chk("mid_reset_hold_outs", 32'(all_outs), 32'd0);
    @(negedge clk_i); rst_ni = 1'b1; dcache_ready_i = 1'b1;
    tick();
    drive_id(INSTR_R, OPC_R, 3'b000, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0);
    tick();
    push_exp(5'd3, 2'd0);
    idle_id();
    @(negedge clk_i);
    chk("rst_add_in_ex_we", 32'(rf_we_wb_o), 32'd0);
    tick();
    @(negedge clk_i);
    chk("rst_add_in_mem_we", 32'(rf_we_wb_o), 32'd0);
    tick();
    @(negedge clk_i);
    chk("rst_add_wb_we", 32'(rf_we_wb_o), 32'd1);
    chk("rst_add_wb_rd", 32'(rd_wb_o), 32'd3);
    chk("rst_timeout_clear", 32'(mem_timeout_o), 32'd0);
    tick();

    // ADD x0 ; ADD x7,x0,x0
    drive_id(INSTR_R, OPC_R, 3'b000, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1);
    tick();
    drive_id(INSTR_R, OPC_R, 3'b000, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1);
    @(negedge clk_i);
    chk("x0_no_stall", 32'(stall_o), 32'd0);
    tick();
    push_exp(5'd7, 2'd0);
    idle_id();
    @(negedge clk_i);
    chk("x0_fwd_sel", 32'({fwd_a_sel_o, fwd_b_sel_o}), 32'd0);
    tick();
    @(negedge clk_i);
    chk("x0_rf_we", 32'(rf_we_wb_o), 32'd0);
    repeat (3) tick();
    chk("final_drain", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/triumph_pipe_ctrl.md
Name: triumph_pipe_ctrl

Overview:
Parametrised successor to the single-stage controller in the Triumph core. It tracks per-stage control words for EX, MEM and WB and drives branch and jump redirects. It detects load-use and memory-wait hazards, generating stall and flush signals. It sits beside the ID/EX/MEM/WB datapath registers and consumes decoded fields from ID plus flags from EX.

Parameters:
RF_ADDR_W, 5, register-file address width (rd/rs1/rs2)
WB_SEL_W, 2, writeback select width (0 ALU, 1 MEM, 2 PC+4)
MEM_WAIT_MAX, 15, dcache wait cycles before mem_timeout_o is raised; 1..2^8-1

Ports:
clk_i  in  1  core clock
rst_ni  in  1  reset, asynchronous, active-low
id_valid_i  in  1  ID holds a valid instruction
instr_type_i  in  3  INSTR_R/I/S/B/U/J code from the shared defines
opcode_i  in  7  RISC-V opcode
funct3_i  in  3  branch/memory sub-op
rs1_i, rs2_i, rd_i  in  RF_ADDR_W each  ID register addresses
use_rs1_i, use_rs2_i  in  1 each  ID actually reads rs1/rs2
flag_zero_ex_i, flag_lt_ex_i, flag_ltu_ex_i  in  1 each  EX compare flags (a==b, signed a<b, unsigned a<b)
dcache_ready_i  in  1  dcache accepts/completes the MEM access this cycle
stall_o  out  1  hold PC, IF/ID and ID/EX
flush_id_o  out  1  kill instruction in ID (bubble into EX next edge)
pc_mux_o  out  2  0 seq, 1 branch target, 2 JAL target, 3 JALR target
dcache_req_o, dcache_we_o  out  1 each  MEM access request / write
wb_sel_o  out  WB_SEL_W  WB source
rf_we_wb_o  out  1  regfile write enable in WB (never for rd==0)
rd_wb_o  out  RF_ADDR_W  WB destination
fwd_a_sel_o, fwd_b_sel_o  out  2 each  EX operand source: 0 RF, 1 MEM result, 2 WB result
mem_timeout_o  out  1  sticky; dcache wait exceeded MEM_WAIT_MAX

Behaviour:
- Control word per stage: {valid, type, is_load, is_store, is_jalr, funct3, rd, we, wb_sel}. The EX, MEM and WB words are registers. Reset (async, rst_ni=0) clears all of them to bubbles (valid=0). All outputs are 0 during and right after reset.
- Decode in ID: load = INSTR_I with OP_LOAD → wb_sel 1. J and JALR → wb_sel 2. S and B → we=0. All other types → wb_sel 0, we=1. we is forced to 0 when rd==0.
- Advance: when stall_o=0, ID→EX, EX→MEM and MEM→WB on each edge.
- States: RUN, MEM_WAIT.
- MEM_WAIT is entered when MEM holds a load/store and dcache_ready_i=0. The whole pipe freezes: stall_o=1 and EX/MEM/WB hold. dcache_req_o stays high. pc_mux_o is forced to 0.
- MEM_WAIT exits to RUN on the cycle dcache_ready_i=1, and the pipe advances on that edge.
- Branch in EX (valid, B): taken by funct3. 000 zero; 001 !zero; 100 lt; 101 !lt; 110 ltu; 111 !ltu; 010/011 never taken.
- Taken branch → pc_mux_o=1 and flush_id_o=1 in the same cycle. J → pc_mux_o=2; JALR → pc_mux_o=3, both always with flush_id_o=1.
- Load-use: EX holds a load with rd≠0 and (use_rs1_i & rs1_i==rd_ex or use_rs2_i & rs2_i==rd_ex) with id_valid_i=1. This gives stall_o=1 for one cycle and a bubble into EX; MEM/WB advance.
- Priority: MEM_WAIT > redirect/flush > load-use. A redirect squashes the ID instruction, so no load-use stall is raised for it.
- Forwarding (feature on): for an EX source, MEM match (valid, we, rd==rs) wins over WB match. rs==0 always gives select 0. The source addresses are the EX-registered rs1/rs2.
- Timeout counter (8 bits): increments each MEM_WAIT cycle and clears on exit. Reaching MEM_WAIT_MAX sets mem_timeout_o, which is cleared only by reset. The counter saturates at MEM_WAIT_MAX.
- dcache_we_o = dcache_req_o & is_store_mem.

Optional Feature:
TRIUMPH_FWD_EN. When defined, the forwarding unit drives fwd_*_sel_o as described above, and only load-use stalls.
When undefined, fwd_*_sel_o are tied to 0. Any RAW match on rs1/rs2 against a valid writer in EX, MEM or WB stalls until the writer has left WB.

Decomposition:
- Shared defines header gains: PC_SEL_* (0..3), WB_SEL_* (0..2), FWD_* (0..2), BR_F3_* funct3 codes, and OP_JALR, OP_JAL. Reuse INSTR_* and OP_LOAD.
- One sub-module: triumph_hazard_unit (combinational load-use/RAW detection plus the forwarding select).

Test Plan:
- Reset: rst_ni=0 mid-stream with a load in MEM → all outputs 0, pipe bubbles; after release an ADD x3 completes with rf_we_wb_o=1, rd_wb_o=3, 3 cycles after entering EX.
- BEQ, funct3=000, zero=1 in EX → pc_mux_o=1, flush_id_o=1 that cycle; next cycle EX valid=0. With zero=0 → pc_mux_o=0, no flush.
- LW x5 then ADD x6,x5,x1 → stall_o=1 for exactly 1 cycle. With TRIUMPH_FWD_EN, the ADD in EX then sees fwd_a_sel_o=2 (WB).
- SW in MEM, dcache_ready_i low 3 cycles → stall_o=1 and dcache_req_o=dcache_we_o=1 for 3 cycles; advance on the 4th. A taken BNE in EX during the wait gives pc_mux_o=0 until the wait ends, then 1.
- MEM_WAIT_MAX=15, ready low 20 cycles → mem_timeout_o rises on the 15th wait cycle and stays 1 after recovery until reset.
- ADD x0 then ADD x7,x0,x0 → rf_we_wb_o=0 for the first; fwd selects stay 0.
